// File: rtl/blinky_led_if.sv
// rtl/blinky_led_if.sv - LED drive bundle for blinky_led
interface blinky_led_if;
    logic led_o;

    modport master (output led_o);
    modport slave  (input  led_o);
endinterface

// File: rtl/blinky_led.sv
// rtl/blinky_led.sv - free-running 50% duty LED blinker
// Optional SVA checks compiled in with BLINKY_LED_ASSERT_EN.
module blinky_led #(
    parameter int CyclesPerToggle = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    blinky_led_if.master      led_if
);

    localparam int CounterWidth = (CyclesPerToggle > 1) ? $clog2(CyclesPerToggle) : 1;
    localparam logic [CounterWidth-1:0] TermCount = CounterWidth'(CyclesPerToggle - 1);

    generate
        if (CyclesPerToggle < 1) begin : g_bad_param
            $error("blinky_led: CyclesPerToggle must be >= 1");
        end
    endgenerate

    logic [CounterWidth-1:0] count_q;
    logic                    led_q;

    // Terminal count is cleared explicitly so non-power-of-two periods are exact.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            led_q   <= 1'b0;
        end else if (count_q == TermCount) begin
            count_q <= '0;
            led_q   <= ~led_q;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign led_if.led_o = led_q;

`ifdef BLINKY_LED_ASSERT_EN
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(count_q) < CyclesPerToggle)
        else $error("blinky_led: count=%0d led=%b out of range", count_q, led_q);

    // A toggle must follow every terminal count and nothing else; together this
    // pins each high and low interval to exactly CyclesPerToggle cycles.
    a_led_change_only_after_term: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ($past(rst_ni) && $changed(led_q)) |-> ($past(count_q) == TermCount))
        else $error("blinky_led: unexpected toggle count=%0d led=%b", count_q, led_q);

    a_led_toggles_after_term: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ($past(rst_ni) && $past(count_q) == TermCount) |-> $changed(led_q))
        else $error("blinky_led: missed toggle count=%0d led=%b", count_q, led_q);

    a_reset_state: assert property (@(posedge clk_i)
        !rst_ni |-> (led_q == 1'b0 && count_q == '0))
        else $error("blinky_led: reset state wrong count=%0d led=%b", count_q, led_q);
`endif

endmodule

// File: tb/tb_blinky_led.sv
// tb/tb_blinky_led.sv - self-checking bench for blinky_led at three periods
module tb_blinky_led;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    blinky_led_if if100 ();
    blinky_led_if if1 ();
    blinky_led_if if5 ();

    blinky_led #(.CyclesPerToggle(100)) u_dut100 (.clk_i(clk), .rst_ni(rst_n), .led_if(if100.master));
    blinky_led #(.CyclesPerToggle(1))   u_dut1   (.clk_i(clk), .rst_ni(rst_n), .led_if(if1.master));
    blinky_led #(.CyclesPerToggle(5))   u_dut5   (.clk_i(clk), .rst_ni(rst_n), .led_if(if5.master));

    // Posedges seen with reset released; cleared asynchronously with the DUTs.
    int n = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // LED is on during every odd block of cpt cycles since release.
    function automatic logic model_led(int cycles, int cpt);
        return ((cycles / cpt) % 2) == 1;
    endfunction

    int   cmp_err = 0;
    int   cmp_chk = 0;
    int   trans   = 0;
    int   last_t  = 0;
    logic prev    = 1'b0;

    always @(negedge clk) begin
        cmp_chk += 3;
        if (if100.led_o !== model_led(n, 100)) begin
            cmp_err++;
            $display("FAIL cmp100 n=%0d got=%b exp=%b", n, if100.led_o, model_led(n, 100));
        end
        if (if1.led_o !== model_led(n, 1)) begin
            cmp_err++;
            $display("FAIL cmp1 n=%0d got=%b exp=%b", n, if1.led_o, model_led(n, 1));
        end
        if (if5.led_o !== model_led(n, 5)) begin
            cmp_err++;
            $display("FAIL cmp5 n=%0d got=%b exp=%b", n, if5.led_o, model_led(n, 5));
        end
        if (!rst_n) begin
            prev   = 1'b0;
            last_t = 0;
        end else if (if100.led_o !== prev) begin
            trans++;
            cmp_chk++;
            if (n - last_t != 100) begin
                cmp_err++;
                $display("FAIL interval100 n=%0d got=%0d exp=100", n, n - last_t);
            end
            last_t = n;
            prev   = if100.led_o;
        end
    end

    int err = 0;
    int chk = 0;

    task automatic chk_lit(input string name, input logic got, input logic exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_lit("rst_hold100", if100.led_o, 1'b0);
            chk_lit("rst_hold1", if1.led_o, 1'b0);
            chk_lit("rst_hold5", if5.led_o, 1'b0);
        end
        rst_n = 1'b1;
        #1 t0 = trans;

        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk_lit("min_cpt_pattern", if1.led_o, logic'(i % 2));
        end
        chk_lit("cpt5_n4", if5.led_o, 1'b0);
        @(negedge clk);
        chk_lit("cpt5_n5", if5.led_o, 1'b1);

        repeat (94) @(negedge clk);
        chk_lit("blink_n99", if100.led_o, 1'b0);
        @(negedge clk);
        chk_lit("blink_rise_n100", if100.led_o, 1'b1);
        repeat (100) @(negedge clk);
        chk_lit("blink_fall_n200", if100.led_o, 1'b0);
        repeat (100) @(negedge clk);
        chk_lit("blink_rise_n300", if100.led_o, 1'b1);

        repeat (1700) @(negedge clk);
        #1;
        chk++;
        if (trans - t0 != 20) begin
            err++;
            $display("FAIL transitions_10_periods got=%0d exp=20", trans - t0);
        end

        repeat (150) @(negedge clk);
        chk_lit("pre_reset_high", if100.led_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_lit("async_rst100", if100.led_o, 1'b0);
        chk_lit("async_rst5", if5.led_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (99) @(negedge clk);
        chk_lit("restart_n99", if100.led_o, 1'b0);
        @(negedge clk);
        chk_lit("restart_rise_n100", if100.led_o, 1'b1);
        repeat (10) @(negedge clk);

        #1;
        $display("Result: errors=%0d of %0d checks", err + cmp_err, chk + cmp_chk);
        $finish;
    end

endmodule
